// File: rtl/loa_acc_pkg.sv
// Shared types and the lower-part-OR (LOA) add function for the approximate accumulator.
package loa_acc_pkg;

  localparam int unsigned IN_W_DEF        = 16;
  localparam int unsigned ACC_W_DEF       = 24;
  localparam int unsigned APPROX_BITS_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 10;
  localparam int unsigned LOA_MAX_W       = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Returns {co, sum} with sum zero-padded in the low LOA_MAX_W bits; w is the
  // active width and l the number of approximate (OR) low bits.
  function automatic logic [LOA_MAX_W:0] loa_add(
    input logic [LOA_MAX_W-1:0] a,
    input logic [LOA_MAX_W-1:0] b,
    input int unsigned          w,
    input int unsigned          l
  );
    logic [LOA_MAX_W:0] r;
    logic               c;
    r = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < LOA_MAX_W; i++) begin
      if (i < l) begin
        r[i] = a[i] | b[i];
        if (i == l - 1) c = a[i] & b[i];
      end else if (i < w) begin
        r[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    r[LOA_MAX_W] = c;
    return r;
  endfunction

endpackage

// File: rtl/loa_add_core.sv
// Combinational ACC_W-bit LOA adder: OR on the low APPROX_BITS, exact add above.
module loa_add_core
  import loa_acc_pkg::*;
#(
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             co
);

  logic [LOA_MAX_W:0] r;

  always_comb r = loa_add(LOA_MAX_W'(a), LOA_MAX_W'(b), ACC_W, APPROX_BITS);

  assign sum = r[ACC_W-1:0];
  assign co  = r[LOA_MAX_W];

  if (ACC_W < LOA_MAX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^r[LOA_MAX_W-1:ACC_W];
  end

endmodule

// File: rtl/loa_accumulator.sv
// Streaming LOA partial-sum accumulator with valid/ready on both sides.
// Define LOA_ACCUMULATOR_ERR_MON_EN to add the exact shadow sum and out_err/out_mismatch.
module loa_accumulator
  import loa_acc_pkg::*;
#(
  parameter int unsigned IN_W        = IN_W_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned APPROX_BITS = APPROX_BITS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`ifdef LOA_ACCUMULATOR_ERR_MON_EN
  ,
  output logic [ACC_W-1:0] out_err,
  output logic             out_mismatch
`endif
);

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_sum, b_ext;
  logic [CNT_W-1:0]   cnt;
  logic               ovf, co, beat, xfer;

  assign b_ext = ACC_W'(in_data);

  loa_add_core #(
    .ACC_W       (ACC_W),
    .APPROX_BITS (APPROX_BITS)
  ) u_add (
    .a   (acc),
    .b   (b_ext),
    .sum (acc_sum),
    .co  (co)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat = in_valid & in_ready;
  assign xfer = out_valid & out_ready;

  // acc/cnt/ovf are frozen in HOLD, so they double as the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (beat) begin
        acc <= acc_sum;
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (co) ovf <= 1'b1;
      end else if (xfer) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign out_data  = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

`ifdef LOA_ACCUMULATOR_ERR_MON_EN
  logic [ACC_W-1:0] exact, exact_sum, err;

  assign exact_sum = exact + b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      exact <= '0;
      err   <= '0;
    end else if (beat) begin
      exact <= exact_sum;
      err   <= (exact_sum >= acc_sum) ? exact_sum - acc_sum : acc_sum - exact_sum;
    end else if (xfer) begin
      exact <= '0;
      err   <= '0;
    end
  end

  assign out_err      = err;
  assign out_mismatch = (err != '0);
`endif

endmodule

// File: tb/tb_loa_accumulator.sv
// Self-checking bench for loa_accumulator: directed table, corner sequences, random vs. model.
module tb_loa_accumulator;

  localparam int W  = 24;
  localparam int L  = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, out_ready, in_ready, out_valid, out_ovf;
  logic [15:0]   in_data;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef LOA_ACCUMULATOR_ERR_MON_EN
  logic [W-1:0]  out_err;
  logic          out_mismatch;
  logic [16:0]   s_out_err;
  logic          s_out_mismatch;
`endif

  logic          s_in_valid, s_in_last, s_out_ready, s_in_ready, s_out_valid, s_out_ovf;
  logic [15:0]   s_in_data;
  logic [16:0]   s_out_data;
  logic [CW-1:0] s_out_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] vbuf [0:1099];
  int          vlen;

  always #5 clk = ~clk;

  loa_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf)
`ifdef LOA_ACCUMULATOR_ERR_MON_EN
    , .out_err(out_err), .out_mismatch(out_mismatch)
`endif
  );

  loa_accumulator #(.ACC_W(17)) dut17 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_count(s_out_count), .out_ovf(s_out_ovf)
`ifdef LOA_ACCUMULATOR_ERR_MON_EN
    , .out_err(s_out_err), .out_mismatch(s_out_mismatch)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Reference: LOA arithmetic from the rule (OR low part, carry from bit L-1, exact upper add).
  function automatic logic [63:0] loa_ref(input logic [63:0] acc, input logic [63:0] b,
                                          input int w, input int l, output bit co);
    logic [63:0] mask, low, hi, c;
    mask = (64'd1 << w) - 1;
    if (l == 0) begin
      hi = acc + b;
      co = hi[w];
      return hi & mask;
    end
    low = (acc | b) & ((64'd1 << l) - 1);
    c   = ((acc & b) >> (l - 1)) & 64'd1;
    hi  = (acc >> l) + (b >> l) + c;
    co  = hi[w - l];
    return ((hi << l) | low) & mask;
  endfunction

  task automatic model_vec(output logic [63:0] d, output logic [63:0] c,
                           output logic [63:0] o, output logic [63:0] e);
    logic [63:0] acc, exact;
    bit co;
    acc = 0; exact = 0; o = 0;
    for (int i = 0; i < vlen; i++) begin
      acc   = loa_ref(acc, 64'(vbuf[i]), W, L, co);
      exact = (exact + 64'(vbuf[i])) & ((64'd1 << W) - 1);
      if (co) o = 1;
    end
    d = acc;
    c = (vlen > 1023) ? 64'd1023 : 64'(vlen);
    e = (exact >= acc) ? exact - acc : acc - exact;
  endtask

  task automatic beat(input logic [15:0] d, input logic l, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = l; n = 0;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (!in_ready) tmo("beat_wait");
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom);
  endtask

  task automatic send_vec(input int gmax);
    for (int i = 0; i < vlen; i++)
      beat(vbuf[i], (i == vlen - 1), (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
  endtask

  task automatic check_result(input string name, input logic [63:0] ed, input logic [63:0] ec,
                              input logic [63:0] eo, input logic [63:0] ee, input int stall);
    int n = 0;
    while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
    if (!out_valid) tmo({name, "_valid"});
    out_ready = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    check({name, "_data"}, 64'(out_data), ed);
    check({name, "_count"}, 64'(out_count), ec);
    check({name, "_ovf"}, 64'(out_ovf), eo);
`ifdef LOA_ACCUMULATOR_ERR_MON_EN
    check({name, "_err"}, 64'(out_err), ee);
    check({name, "_mismatch"}, 64'(out_mismatch), 64'(ee != 0));
`else
    if (ee > 64'hFFFF_FFFF_FFFF) $display("note: unexpected model error magnitude");
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_done"}, 64'(out_valid), 0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] d [4];
    logic [23:0] exp_data;
    logic [9:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [5];
    logic [63:0] md, mc, mo, me;
    logic [W-1:0] held;

    tbl[0] = '{2, '{16'h0003, 16'h0005, 16'h0, 16'h0}, 24'h000007, 10'd2, 1'b0};
    tbl[1] = '{2, '{16'h0008, 16'h0008, 16'h0, 16'h0}, 24'h000018, 10'd2, 1'b0};
    tbl[2] = '{1, '{16'hABCD, 16'h0, 16'h0, 16'h0}, 24'h00ABCD, 10'd1, 1'b0};
    tbl[3] = '{4, '{16'h0001, 16'h0002, 16'h0004, 16'h0008}, 24'h00000F, 10'd4, 1'b0};
    tbl[4] = '{4, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 24'h03FFFF, 10'd4, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_count", 64'(out_count), 0);
    check("rst_out_ovf", 64'(out_ovf), 0);
    check("rst_in_ready", 64'(in_ready), 1);

    for (int t = 0; t < 5; t++) begin
      vlen = tbl[t].n;
      for (int i = 0; i < vlen; i++) vbuf[i] = tbl[t].d[i];
      model_vec(md, mc, mo, me);
      send_vec(0);
      check($sformatf("tbl%0d_latency", t), 64'(out_valid), 1);
      check_result($sformatf("tbl%0d", t), 64'(tbl[t].exp_data), 64'(tbl[t].exp_cnt),
                   64'(tbl[t].exp_ovf), me, 0);
    end

    // Backpressure: result stays put, input blocked, junk on the input is ignored.
    beat(16'h0003, 1'b0, 0);
    beat(16'h0005, 1'b1, 0);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 0);
      check($sformatf("bp_valid_%0d", i), 64'(out_valid), 1);
      check($sformatf("bp_data_%0d", i), 64'(out_data), 64'h7);
      check($sformatf("bp_stable_%0d", i), 64'(out_data), 64'(held));
      check($sformatf("bp_count_%0d", i), 64'(out_count), 2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 0);
    check("bp_release_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_single_xfer", 64'(out_valid), 0);

    // Reset mid-vector discards the partial sum.
    beat(16'h0100, 1'b0, 0);
    beat(16'h0200, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_data", 64'(out_data), 0);
    check("midrst_count", 64'(out_count), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    beat(16'h0004, 1'b1, 0);
    check_result("midrst_vec", 64'h4, 64'd1, 0, 0, 0);

    // Reset while holding a result.
    beat(16'h1234, 1'b1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("holdrst_valid", 64'(out_valid), 0);
    check("holdrst_data", 64'(out_data), 0);

    // Narrow accumulator: upper-part carry-out sets the sticky overflow.
    s_in_valid = 1'b1; s_in_data = 16'hFFFF; s_in_last = 1'b0;
    check("w17_in_ready", 64'(s_in_ready), 1);
    @(posedge clk); #1;
    s_in_data = 16'hFFFF;
    @(posedge clk); #1;
    s_in_data = 16'h0010; s_in_last = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("w17_valid", 64'(s_out_valid), 1);
    check("w17_data", 64'(s_out_data), 64'h0000F);
    check("w17_count", 64'(s_out_count), 3);
    check("w17_ovf", 64'(s_out_ovf), 1);

    // Count saturation with random operands.
    vlen = 1030;
    for (int i = 0; i < vlen; i++) vbuf[i] = 16'($urandom);
    model_vec(md, mc, mo, me);
    send_vec(0);
    check_result("sat", md, mc, mo, me, 2);

    // Random vectors with input gaps and output stalls.
    for (int v = 0; v < 40; v++) begin
      vlen = int'($urandom_range(1, 8));
      for (int i = 0; i < vlen; i++) vbuf[i] = 16'($urandom);
      model_vec(md, mc, mo, me);
      send_vec(2);
      check_result($sformatf("rnd%0d", v), md, mc, mo, me, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
